// File: rtl/serial_adder_ctrl_pkg.sv
// Shared types and helpers for the bit-serial add/subtract engine.
// FSM state encoding is fixed binary so the display front end can decode it if needed.
package serial_adder_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder; purely combinational, carry is registered by the caller.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ c;
    assign cout = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller: parallel load on start, one bit per clock LSB first,
// registered result/carry/overflow presented with a one-cycle done pulse.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned CntW = cnt_width(WIDTH);
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opb_q, res_q, sum_q;
    logic             carry_q, cout_q, ovf_q;
    logic [CntW-1:0]  cnt_q;

    logic fa_s, fa_c;
    logic load, last_bit;

    full_adder_cell u_fa (
        .a    (opa_q[0]),
        .b    (opb_q[0]),
        .c    (carry_q),
        .s    (fa_s),
        .cout (fa_c)
    );

    assign load     = start && ((state_q == StIdle) || (state_q == StDone));
    assign last_bit = (state_q == StShift) && (cnt_q == LastBit);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StShift;
            StShift: if (cnt_q == LastBit) state_d = StDone;
            StDone:  state_d = start ? StShift : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                opa_q   <= a_in;
                opb_q   <= sub ? ~b_in : b_in;
                carry_q <= sub ? 1'b1 : cin;
                cnt_q   <= '0;
            end else if (state_q == StShift) begin
                res_q   <= {fa_s, res_q[WIDTH-1:1]};
                opa_q   <= {1'b0, opa_q[WIDTH-1:1]};
                opb_q   <= {1'b0, opb_q[WIDTH-1:1]};
                carry_q <= fa_c;
                cnt_q   <= cnt_q + CntW'(1);
                // carry_q here is the carry into the MSB
                if (last_bit) begin
                    sum_q  <= {fa_s, res_q[WIDTH-1:1]};
                    cout_q <= fa_c;
                    ovf_q  <= carry_q ^ fa_c;
                end
            end
        end
    end

    assign ready = (state_q == StIdle) || (state_q == StDone);
    assign busy  = (state_q == StShift);
    assign done  = (state_q == StDone);
    assign sum   = sum_q;
    assign cout  = cout_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and random checks of serial_adder_ctrl (WIDTH=8) against an arithmetic reference model.
module tb_serial_adder_ctrl;

    localparam int unsigned W = 8;

    logic         clk, rst, start, sub, cin;
    logic [W-1:0] a_in, b_in;
    logic         ready, busy, done, cout, ovf;
    logic [W-1:0] sum;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] held_sum;
    logic         held_cout, held_ovf;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .a_in  (a_in),
        .b_in  (b_in),
        .cin   (cin),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Plain integer arithmetic: signed range test for overflow, unsigned compare for carry.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                                  input logic s, output logic [W-1:0] es, output logic ec,
                                  output logic eo);
        int sa, sb, ci, r, ua, ub;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        ci = c;
        if (s) begin
            r  = sa - sb;
            es = W'(ua - ub);
            ec = (ua >= ub);
        end else begin
            r  = sa + sb + ci;
            es = W'(ua + ub + ci);
            ec = (ua + ub + ci) > 255;
        end
        eo = (r < -128) || (r > 127);
    endfunction

    // Issues start in the current cycle; returns in the done cycle without stepping past it.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input logic s, input int poke_at, input bit detail);
        logic [W-1:0] es;
        logic         ec, eo;
        model(a, b, c, s, es, ec, eo);
        a_in  = a;
        b_in  = b;
        cin   = c;
        sub   = s;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= W; k++) begin
            if (k == poke_at) begin
                start = 1'b1;
                a_in  = ~a;
                b_in  = a;
                sub   = ~s;
            end else begin
                start = 1'b0;
            end
            if (detail || k == 1) begin
                chk("busy_in_shift", busy, 1);
                chk("no_done_in_shift", done, 0);
                chk("not_ready_in_shift", ready, 0);
                chk("sum_held", sum, held_sum);
            end
            step();
        end
        start = 1'b0;
        chk("done_pulse", done, 1);
        chk("busy_after", busy, 0);
        chk("sum", sum, es);
        chk("cout", cout, ec);
        chk("ovf", ovf, eo);
        held_sum  = es;
        held_cout = ec;
        held_ovf  = eo;
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic         rc, rs;

        rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a_in = '0; b_in = '0;
        held_sum = '0; held_cout = 1'b0; held_ovf = 1'b0;
        step();
        step();
        chk("rst_ready", ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", ovf, 0);
        rst = 1'b0;
        step();

        // Directed arithmetic cases
        run_op(8'h0F, 8'h01, 1'b0, 1'b0, 0, 1'b1);
        step();
        chk("done_one_cycle", done, 0);
        chk("idle_ready", ready, 1);
        chk("sum_held_idle", sum, held_sum);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 0, 1'b1);
        step();
        run_op(8'hFF, 8'h00, 1'b1, 1'b0, 0, 1'b1);
        step();
        run_op(8'h05, 8'h07, 1'b1, 1'b1, 0, 1'b1);
        step();
        run_op(8'h80, 8'h01, 1'b0, 1'b1, 0, 1'b1);
        step();
        // Second start at T+3 must be ignored
        run_op(8'h7F, 8'h01, 1'b0, 1'b0, 3, 1'b1);
        step();
        chk("no_spurious_op", busy, 0);

        // Reset asserted in cycle T+4 abandons the operation
        a_in = 8'h33; b_in = 8'h44; cin = 1'b0; sub = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_ready", ready, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_sum", sum, 0);
        chk("mid_rst_cout", cout, 0);
        chk("mid_rst_ovf", ovf, 0);
        held_sum = '0;
        for (int k = 0; k < 10; k++) begin
            chk("no_done_after_rst", done, 0);
            step();
        end
        run_op(8'h12, 8'h34, 1'b1, 1'b0, 0, 1'b1);

        // Back-to-back: next start lands in the done cycle
        run_op(8'hA5, 8'h5A, 1'b0, 1'b1, 0, 1'b1);
        run_op(8'h01, 8'h02, 1'b0, 1'b1, 0, 1'b1);
        step();
        chk("b2b_done_drops", done, 0);

        // Random vectors, chained back-to-back
        for (int n = 0; n < 1000; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            rs = 1'($urandom);
            run_op(ra, rb, rc, rs, 0, 1'b0);
        end
        step();
        chk("final_idle", ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
